// File: rtl/alu_mdu_if.sv
// Handshake bundle between issue, the alu_mdu execution unit and writeback.
//   flush              : abandon in-flight op and any held result
//   in_valid/in_ready  : issue-side handshake carrying op, op_w, a, b
//   out_valid/out_ready: writeback-side handshake carrying result
// master = issue/writeback side, slave = execution unit.
interface alu_mdu_if #(
  parameter int unsigned XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic            op_w;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output flush, in_valid, op, op_w, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  flush, in_valid, op, op_w, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/alu_mdu.sv
// Handshaked integer execution unit: ten single-cycle ALU ops, iterative
// RV-M multiply/divide/remainder (one shift-add or restoring step per cycle),
// and RV64 word mode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_mdu_if slave (flush, in_* issue side, out_* result side)
module alu_mdu #(
  parameter int unsigned XLEN = 64
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mdu_if.slave bus
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic [XLEN-1:0]   result_q;
  logic [XLEN-1:0]   hi, lo, opnd;
  logic [CW-1:0]     cnt;
  logic              m_mul, m_high, m_rem, m_word, m_neg, m_neg_r, m_div0;

  logic              word_c, is_mul_c, is_multi_c, sgn_div_c, sa_c, sb_c;
  logic              accept_c;
  logic [XLEN-1:0]   sum_c, dif_c, alu_c, ea_c, eb_c, xa_c, xb_c, ma_c, mb_c;
  logic signed [XLEN-1:0] sra_c;
  logic signed [31:0]     sraw_c;
  logic [XLEN:0]     msum_c, shl_c, dsub_c;
  logic [XLEN-1:0]   nhi_c, nlo_c, quo_c, rem_c, raw_c, fin_c;
  logic [2*XLEN-1:0] prod_c;

  function automatic logic [XLEN-1:0] sx(input logic [31:0] x);
    return XLEN'($signed(x));
  endfunction

  assign bus.in_ready  = !bus.flush && (state == IDLE || (state == DONE && bus.out_ready));
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign accept_c      = bus.in_valid && bus.in_ready;

  // Single-cycle ALU result
  always_comb begin
    word_c = bus.op_w && (XLEN == 64);
    sum_c  = bus.a + bus.b;
    dif_c  = bus.a - bus.b;
    sra_c  = $signed(bus.a) >>> bus.b[SHW-1:0];
    sraw_c = $signed(bus.a[31:0]) >>> bus.b[4:0];
    alu_c  = '0;
    case (bus.op)
      5'd0:    alu_c = word_c ? sx(sum_c[31:0]) : sum_c;
      5'd1:    alu_c = word_c ? sx(dif_c[31:0]) : dif_c;
      5'd2:    alu_c = bus.a & bus.b;
      5'd3:    alu_c = bus.a | bus.b;
      5'd4:    alu_c = bus.a ^ bus.b;
      5'd5:    alu_c = XLEN'($signed(bus.a) < $signed(bus.b));
      5'd6:    alu_c = XLEN'(bus.a < bus.b);
      5'd7:    alu_c = word_c ? sx(bus.a[31:0] << bus.b[4:0]) : bus.a << bus.b[SHW-1:0];
      5'd8:    alu_c = word_c ? sx(bus.a[31:0] >> bus.b[4:0]) : bus.a >> bus.b[SHW-1:0];
      5'd9:    alu_c = word_c ? sx(sraw_c) : $unsigned(sra_c);
      default: alu_c = '0;
    endcase
  end

  // Operand conditioning for mul/div: effective operands, then magnitudes
  always_comb begin
    is_mul_c   = bus.op inside {[5'd10:5'd13]};
    is_multi_c = bus.op inside {[5'd10:5'd17]};
    sgn_div_c  = (bus.op == 5'd14) || (bus.op == 5'd16);
    ea_c = bus.a;
    eb_c = bus.b;
    if (word_c) begin
      ea_c = sgn_div_c ? sx(bus.a[31:0]) : XLEN'(bus.a[31:0]);
      eb_c = sgn_div_c ? sx(bus.b[31:0]) : XLEN'(bus.b[31:0]);
    end
    xa_c = is_mul_c ? bus.a : ea_c;
    xb_c = is_mul_c ? bus.b : eb_c;
    sa_c = xa_c[XLEN-1] && (is_mul_c ? (bus.op == 5'd11 || bus.op == 5'd12) : sgn_div_c);
    sb_c = xb_c[XLEN-1] && (is_mul_c ? (bus.op == 5'd11) : sgn_div_c);
    ma_c = sa_c ? -xa_c : xa_c;
    mb_c = sb_c ? -xb_c : xb_c;
  end

  // One iteration: shift-add multiply into {hi,lo}, or restoring divide step
  always_comb begin
    nhi_c  = hi;
    nlo_c  = lo;
    msum_c = {1'b0, hi} + ({1'b0, opnd} & {(XLEN+1){lo[0]}});
    shl_c  = {hi, lo[XLEN-1]};
    dsub_c = shl_c - {1'b0, opnd};
    if (m_mul) begin
      {nhi_c, nlo_c} = {msum_c, lo[XLEN-1:1]};
    end else if (dsub_c[XLEN]) begin
      nhi_c = shl_c[XLEN-1:0];
      nlo_c = {lo[XLEN-2:0], 1'b0};
    end else begin
      nhi_c = dsub_c[XLEN-1:0];
      nlo_c = {lo[XLEN-2:0], 1'b1};
    end
  end

  // Final sign fix-up and selection, taken from the last iteration's values
  always_comb begin
    prod_c = m_neg ? -{nhi_c, nlo_c} : {nhi_c, nlo_c};
    quo_c  = m_div0 ? '1 : (m_neg ? -nlo_c : nlo_c);
    rem_c  = m_neg_r ? -nhi_c : nhi_c;
    if (m_mul) raw_c = m_high ? prod_c[2*XLEN-1:XLEN] : prod_c[XLEN-1:0];
    else       raw_c = m_rem ? rem_c : quo_c;
    fin_c = m_word ? sx(raw_c[31:0]) : raw_c;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      result_q <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      m_mul    <= 1'b0;
      m_high   <= 1'b0;
      m_rem    <= 1'b0;
      m_word   <= 1'b0;
      m_neg    <= 1'b0;
      m_neg_r  <= 1'b0;
      m_div0   <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept_c) begin
            if (is_multi_c) begin
              hi      <= '0;
              lo      <= is_mul_c ? mb_c : ma_c;
              opnd    <= is_mul_c ? ma_c : mb_c;
              cnt     <= '0;
              m_mul   <= is_mul_c;
              m_high  <= (bus.op != 5'd10);
              m_rem   <= (bus.op == 5'd16) || (bus.op == 5'd17);
              m_word  <= word_c && (bus.op == 5'd10 || bus.op >= 5'd14);
              m_neg   <= sa_c ^ sb_c;
              m_neg_r <= sa_c;
              m_div0  <= (xb_c == '0);
              state   <= BUSY;
            end else begin
              result_q <= alu_c;
              state    <= DONE;
            end
          end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          hi <= nhi_c;
          lo <= nlo_c;
          if (cnt == CW'(XLEN - 1)) begin
            result_q <= fin_c;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (XLEN=64): directed and random ops checked
// against a plain-arithmetic reference model, with latency and handshake checks.
module tb_alu_mdu;
  localparam int unsigned XLEN = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n;

  alu_mdu_if #(.XLEN(XLEN)) bus ();
  alu_mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    logic [63:0] exp;
    int          due;
    bit          seen;
  } ent_t;
  ent_t q[$];
  ent_t h, e;

  function automatic logic [63:0] sx(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference: full-width products and native division with RISC-V special cases
  function automatic logic [63:0] model(input logic [4:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pa, pb, p;
    logic [63:0] ea, eb, qv, rv, res;
    logic signed [63:0] sra64;
    logic signed [31:0] sra32;
    logic sg;
    sra64 = $signed(a) >>> b[5:0];
    sra32 = $signed(a[31:0]) >>> b[4:0];
    sg = (op == 5'd14) || (op == 5'd16);
    ea = w ? (sg ? sx(a[31:0]) : {32'h0, a[31:0]}) : a;
    eb = w ? (sg ? sx(b[31:0]) : {32'h0, b[31:0]}) : b;
    pa = (op == 5'd11 || op == 5'd12) ? {{64{a[63]}}, a} : {64'h0, a};
    pb = (op == 5'd11) ? {{64{b[63]}}, b} : {64'h0, b};
    p  = pa * pb;
    if (eb == 64'h0) begin
      qv = ONES; rv = ea;
    end else if (sg && ea == MINV && eb == ONES) begin
      qv = ea; rv = 64'h0;
    end else if (sg) begin
      qv = $signed(ea) / $signed(eb);
      rv = $signed(ea) % $signed(eb);
    end else begin
      qv = ea / eb;
      rv = ea % eb;
    end
    case (op)
      5'd0:                res = w ? sx(32'(a + b)) : a + b;
      5'd1:                res = w ? sx(32'(a - b)) : a - b;
      5'd2:                res = a & b;
      5'd3:                res = a | b;
      5'd4:                res = a ^ b;
      5'd5:                res = {63'h0, $signed(a) < $signed(b)};
      5'd6:                res = {63'h0, a < b};
      5'd7:                res = w ? sx(a[31:0] << b[4:0]) : a << b[5:0];
      5'd8:                res = w ? sx(a[31:0] >> b[4:0]) : a >> b[5:0];
      5'd9:                res = w ? sx(sra32) : sra64;
      5'd10:               res = w ? sx(p[31:0]) : p[63:0];
      5'd11, 5'd12, 5'd13: res = p[127:64];
      5'd14, 5'd15:        res = w ? sx(qv[31:0]) : qv;
      5'd16, 5'd17:        res = w ? sx(rv[31:0]) : rv;
      default:             res = 64'h0;
    endcase
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every output-valid cycle against the model's queue
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      chk("reset_out_valid", 64'(bus.out_valid), 64'h0);
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(bus.out_valid), 64'h0);
        end else begin
          h = q[0];
          chk("result", bus.result, h.exp);
          if (!h.seen) begin
            chk("latency", 64'(cyc), 64'(h.due));
            h.seen = 1'b1;
            q[0] = h;
          end
          if (bus.out_ready && !bus.flush) void'(q.pop_front());
        end
      end else if (q.size() > 0) begin
        chk("in_ready_busy", 64'(bus.in_ready), 64'h0);
        if (cyc >= q[0].due) chk("late_out_valid", 64'(bus.out_valid), 64'h1);
      end
      if (bus.flush) begin
        chk("in_ready_flush", 64'(bus.in_ready), 64'h0);
        q.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        e.exp  = model(bus.op, bus.op_w, bus.a, bus.b);
        e.due  = cyc + ((bus.op inside {[5'd10:5'd17]}) ? 65 : 1);
        e.seen = 1'b0;
        q.push_back(e);
      end
    end
  end

  // Present one op and hold it until accepted; returns just after the accept edge
  task automatic send(input logic [4:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = op; bus.op_w = w; bus.a = a; bus.b = b;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = bus.in_ready;
    end
    if (!got) chk("accept_timeout", 64'(bus.in_ready), 64'h1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = bus.out_valid && bus.out_ready;
    end
    if (!done) chk("result_timeout", 64'(bus.out_valid), 64'h1);
    @(posedge clk); #1;
  endtask

  task automatic pin(input string name, input logic [4:0] op, input logic w,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] lit);
    chk({"model_", name}, model(op, w, a, b), lit);
    send(op, w, a, b);
    drain();
  endtask

  function automatic logic [63:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 64'h0;
      1:       return 64'h1;
      2:       return ONES;
      3:       return MINV;
      4:       return sx(32'h8000_0000);
      5:       return 64'($urandom_range(0, 100));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic [4:0]  rop;
    logic [63:0] ra, rb;
    bit done;
    rst_n = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = 5'd0; bus.op_w = 1'b0;
    bus.a = 64'h0; bus.b = 64'h0; bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_result", bus.result, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    pin("add",    5'd0,  1'b0, ONES, 64'h1, 64'h0);
    pin("addw",   5'd0,  1'b1, 64'h7FFF_FFFF, 64'h1, 64'hFFFF_FFFF_8000_0000);
    pin("sra",    5'd9,  1'b0, MINV, 64'd63, ONES);
    pin("sraw",   5'd9,  1'b1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
    pin("sltu",   5'd6,  1'b0, 64'h1, ONES, 64'h1);
    pin("mulh",   5'd11, 1'b0, -64'sd2, 64'd3, ONES);
    pin("mulhu",  5'd13, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
    pin("div",    5'd14, 1'b0, -64'sd7, 64'd2, -64'sd3);
    pin("rem",    5'd16, 1'b0, -64'sd7, 64'd2, ONES);
    pin("divu0",  5'd15, 1'b0, 64'h1234_5678, 64'h0, ONES);
    pin("remu0",  5'd17, 1'b0, 64'h1234_5678, 64'h0, 64'h1234_5678);
    pin("div_ov", 5'd14, 1'b0, MINV, ONES, MINV);
    pin("rem_ov", 5'd16, 1'b0, MINV, ONES, 64'h0);
    pin("divw",   5'd14, 1'b1, 64'h8000_0000, ONES, 64'hFFFF_FFFF_8000_0000);

    // Back-to-back single-cycle ops, one accept per cycle
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.op = 5'($urandom_range(0, 9)); bus.op_w = 1'($urandom_range(0, 1));
      bus.a = rnd_opnd(); bus.b = rnd_opnd();
      @(negedge clk);
      chk("b2b_in_ready", 64'(bus.in_ready), 64'h1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain();

    // Backpressure then same-cycle release with a new op
    bus.out_ready = 1'b0;
    send(5'd4, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(bus.out_valid), 64'h1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'h0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(5'd1, 1'b0, 64'd100, 64'd58);
    drain();

    // Flush in BUSY together with a new op
    send(5'd15, 1'b0, {$urandom(), $urandom()}, 64'd7);
    repeat (19) @(posedge clk);
    #1;
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = 5'd0; bus.a = 64'd1; bus.b = 64'd2;
    @(negedge clk);
    chk("flush_in_ready", 64'(bus.in_ready), 64'h0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_out_valid", 64'(bus.out_valid), 64'h0);
    chk("post_flush_idle", 64'(bus.in_ready), 64'h1);
    repeat (70) @(negedge clk);
    chk("flush_no_result", 64'(bus.out_valid), 64'h0);
    @(posedge clk); #1;

    // Reset in the middle of BUSY
    send(5'd13, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("midrst_result", bus.result, 64'h0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'h1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Random ops with random output stalls
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) < 4) rop = 5'($urandom_range(10, 17));
      else                          rop = 5'($urandom_range(0, 31));
      ra = rnd_opnd(); rb = rnd_opnd();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      send(rop, 1'($urandom_range(0, 1)), ra, rb);
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
        @(negedge clk);
        done = bus.out_valid && bus.out_ready;
        @(posedge clk); #1;
        if (!done) bus.out_ready = ($urandom_range(0, 2) != 0);
      end
      if (!done) chk("rand_timeout", 64'(bus.out_valid), 64'h1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("final_queue_empty", 64'(q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
